// File: rtl/id_ex_alu_issue.sv
// Decode-and-issue stage: turns a MIPS-I instruction plus register operands into
// ALU op/operands and memory/writeback/branch control, registered in ID/EX.
module id_ex_alu_issue #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  input  logic [31:0]  instr,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] rt_data,
  input  logic         stall,
  input  logic         flush,
  output logic         ex_valid,
  output logic [3:0]   ex_op_code,
  output logic [N-1:0] ex_operand1,
  output logic [N-1:0] ex_operand2,
  output logic [N-1:0] ex_store_data,
  output logic [4:0]   ex_dest_reg,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic         ex_branch,
  output logic         ex_branch_ne,
  output logic         ex_illegal
);

  typedef enum logic [3:0] {
    ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_SRA = 4'd2, ALU_ADD = 4'd3, ALU_SUB = 4'd4,
    ALU_AND = 4'd5, ALU_OR  = 4'd6, ALU_XOR = 4'd7, ALU_NOR = 4'd8, ALU_SLT = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic         valid;
    alu_op_t      op;
    logic [N-1:0] operand1;
    logic [N-1:0] operand2;
    logic [N-1:0] store_data;
    logic [4:0]   dest;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         branch;
    logic         branch_ne;
    logic         illegal;
  } id_ex_t;

  logic [5:0]   opcode, funct;
  logic [4:0]   rt, rd;
  logic [N-1:0] imm_se, imm_ze, shamt_ze;
  logic         legal;
  id_ex_t       dec, ex_q;

  assign opcode   = instr[31:26];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_se   = N'($signed(instr[15:0]));
  assign imm_ze   = N'(instr[15:0]);
  assign shamt_ze = N'(instr[10:6]);

  // The rs index is resolved by the register file; only rs_data is consumed here.
  logic unused_rs;
  assign unused_rs = ^instr[25:21];

  always_comb begin
    // NOTE: every field gets a default before the case so no path can infer a latch.
    dec            = '0;
    legal          = 1'b1;
    dec.store_data = rt_data;
    dec.operand1   = rs_data;
    unique case (opcode)
      6'h00: begin
        dec.dest      = rd;
        dec.reg_write = 1'b1;
        dec.operand2  = rt_data;
        unique case (funct)
          6'h00: begin dec.op = ALU_SLL; dec.operand1 = shamt_ze; end
          6'h02: begin dec.op = ALU_SRL; dec.operand1 = shamt_ze; end
          6'h03: begin dec.op = ALU_SRA; dec.operand1 = shamt_ze; end
          6'h04: dec.op = ALU_SLL;
          6'h06: dec.op = ALU_SRL;
          6'h07: dec.op = ALU_SRA;
          6'h20, 6'h21: dec.op = ALU_ADD;
          6'h22, 6'h23: dec.op = ALU_SUB;
          6'h24: dec.op = ALU_AND;
          6'h25: dec.op = ALU_OR;
          6'h26: dec.op = ALU_XOR;
          6'h27: dec.op = ALU_NOR;
          6'h2A: dec.op = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec.op = ALU_ADD; dec.operand2 = imm_se; dec.dest = rt; dec.reg_write = 1'b1; end
      6'h0A: begin dec.op = ALU_SLT; dec.operand2 = imm_se; dec.dest = rt; dec.reg_write = 1'b1; end
      6'h0C: begin dec.op = ALU_AND; dec.operand2 = imm_ze; dec.dest = rt; dec.reg_write = 1'b1; end
      6'h0D: begin dec.op = ALU_OR;  dec.operand2 = imm_ze; dec.dest = rt; dec.reg_write = 1'b1; end
      6'h0E: begin dec.op = ALU_XOR; dec.operand2 = imm_ze; dec.dest = rt; dec.reg_write = 1'b1; end
      // LUI reuses the shifter: imm << 16.
      6'h0F: begin
        dec.op = ALU_SLL; dec.operand1 = N'(16); dec.operand2 = imm_ze;
        dec.dest = rt; dec.reg_write = 1'b1;
      end
      6'h23: begin
        dec.op = ALU_ADD; dec.operand2 = imm_se; dec.dest = rt;
        dec.reg_write = 1'b1; dec.mem_read = 1'b1;
      end
      6'h2B: begin dec.op = ALU_ADD; dec.operand2 = imm_se; dec.dest = rt; dec.mem_write = 1'b1; end
      6'h04, 6'h05: begin
        dec.op = ALU_SUB; dec.operand2 = rt_data; dec.dest = rt;
        dec.branch = 1'b1; dec.branch_ne = opcode[0];
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else begin
      dec.valid = 1'b1;
      if (dec.dest == 5'd0) dec.reg_write = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ex_q <= '0;
    else if (flush)        ex_q <= '0;
    else if (stall)        ex_q.illegal <= 1'b0;
    else if (!instr_valid) ex_q <= '0;
    else                   ex_q <= dec;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_op_code    = ex_q.op;
  assign ex_operand1   = ex_q.operand1;
  assign ex_operand2   = ex_q.operand2;
  assign ex_store_data = ex_q.store_data;
  assign ex_dest_reg   = ex_q.dest;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_branch_ne  = ex_q.branch_ne;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Bench for id_ex_alu_issue: directed scenarios with hand-derived expectations
// plus randomized traffic scored against a decode-table reference model.
module tb_id_ex_alu_issue;

  localparam int N = 32;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] st;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, bne, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, stall, flush;
  logic [31:0] instr, rs_data, rt_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne, ex_illegal;
  logic [3:0]  ex_op_code;
  logic [31:0] ex_operand1, ex_operand2, ex_store_data;
  logic [4:0]  ex_dest_reg;

  exp_t act, exp_q, want;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_op_code(ex_op_code), .ex_operand1(ex_operand1),
    .ex_operand2(ex_operand2), .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_illegal(ex_illegal)
  );

  always_comb act = {ex_valid, ex_op_code, ex_operand1, ex_operand2, ex_store_data, ex_dest_reg,
                     ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne, ex_illegal};

  function automatic exp_t mk(logic v, logic [3:0] op, logic [31:0] o1, logic [31:0] o2,
                              logic [31:0] st, logic [4:0] d, logic rw, logic mr, logic mw,
                              logic br, logic bne, logic ill);
    return {v, op, o1, o2, st, d, rw, mr, mw, br, bne, ill};
  endfunction

  // Reference decode straight from the instruction-set table.
  function automatic exp_t model_decode(logic [31:0] i, logic [31:0] a, logic [31:0] b);
    exp_t e;
    logic [31:0] se = {{16{i[15]}}, i[15:0]};
    logic [31:0] ze = {16'h0, i[15:0]};
    logic [31:0] sh = {27'h0, i[10:6]};
    logic ill = 1'b0;
    e = '0;
    e.valid = 1'b1; e.st = b; e.o1 = a; e.dest = i[20:16]; e.rw = 1'b1;
    case (i[31:26])
      6'h00: begin
        e.dest = i[15:11]; e.o2 = b;
        case (i[5:0])
          6'h00: begin e.op = 0; e.o1 = sh; end
          6'h02: begin e.op = 1; e.o1 = sh; end
          6'h03: begin e.op = 2; e.o1 = sh; end
          6'h04: e.op = 0;
          6'h06: e.op = 1;
          6'h07: e.op = 2;
          6'h20, 6'h21: e.op = 3;
          6'h22, 6'h23: e.op = 4;
          6'h24: e.op = 5;
          6'h25: e.op = 6;
          6'h26: e.op = 7;
          6'h27: e.op = 8;
          6'h2A: e.op = 9;
          default: ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin e.op = 3; e.o2 = se; end
      6'h0A: begin e.op = 9; e.o2 = se; end
      6'h0C: begin e.op = 5; e.o2 = ze; end
      6'h0D: begin e.op = 6; e.o2 = ze; end
      6'h0E: begin e.op = 7; e.o2 = ze; end
      6'h0F: begin e.op = 0; e.o1 = 32'd16; e.o2 = ze; end
      6'h23: begin e.op = 3; e.o2 = se; e.mr = 1'b1; end
      6'h2B: begin e.op = 3; e.o2 = se; e.mw = 1'b1; e.rw = 1'b0; end
      6'h04, 6'h05: begin
        e.op = 4; e.o2 = b; e.br = 1'b1; e.bne = (i[31:26] == 6'h05); e.rw = 1'b0;
      end
      default: ill = 1'b1;
    endcase
    if (e.dest == 0) e.rw = 1'b0;
    if (ill) begin e = '0; e.ill = 1'b1; end
    return e;
  endfunction

  function automatic exp_t model_next(exp_t cur);
    exp_t n;
    if (flush)             n = '0;
    else if (stall)        begin n = cur; n.ill = 1'b0; end
    else if (!instr_valid) n = '0;
    else                   n = model_decode(instr, rs_data, rt_data);
    return n;
  endfunction

  // Drive on the falling edge, advance through the rising edge, sample 1 time unit later.
  task automatic step(logic v, logic [31:0] i, logic [31:0] a, logic [31:0] b, logic s, logic f);
    @(negedge clk);
    instr_valid = v; instr = i; rs_data = a; rt_data = b; stall = s; flush = f;
    @(posedge clk);
    exp_q = rst_n ? model_next(exp_q) : '0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b1; instr = 32'h2109FFFB; rs_data = 32'h10; rt_data = 32'h1;
    stall = 1'b0; flush = 1'b0; exp_q = '0;
    #3;
    tests++;
    if (act !== '0) begin failed++; $display("FAIL reset_async: got %h want 0", act); end
    step(1'b1, 32'h2109FFFB, 32'h10, 32'h1, 1'b0, 1'b0);
    tests++;
    if (act !== '0) begin failed++; $display("FAIL reset_held: got %h want 0", act); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_addi();
    step(1'b1, 32'h2109FFFB, 32'h10, 32'h55, 1'b0, 1'b0);
    want = mk(1, 3, 32'h10, 32'hFFFFFFFB, 32'h55, 9, 1, 0, 0, 0, 0, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL addi: got %h want %h", act, want); end
  endtask

  task automatic test_shift_lui();
    step(1'b1, 32'h00095100, 32'h77, 32'h3, 1'b0, 1'b0);
    want = mk(1, 0, 32'd4, 32'd3, 32'd3, 10, 1, 0, 0, 0, 0, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL sll: got %h want %h", act, want); end
    step(1'b1, 32'h3C081234, 32'h0, 32'hAB, 1'b0, 1'b0);
    want = mk(1, 0, 32'd16, 32'h1234, 32'hAB, 8, 1, 0, 0, 0, 0, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL lui: got %h want %h", act, want); end
  endtask

  task automatic test_store_branch();
    step(1'b1, 32'hAD090008, 32'h100, 32'hCAFE, 1'b0, 1'b0);
    want = mk(1, 3, 32'h100, 32'h8, 32'hCAFE, 9, 0, 0, 1, 0, 0, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL sw: got %h want %h", act, want); end
    // BNE $8,$9: subtract compare, no writeback even though rt != 0.
    step(1'b1, 32'h1509FFFE, 32'h5, 32'h6, 1'b0, 1'b0);
    want = mk(1, 4, 32'h5, 32'h6, 32'h6, 9, 0, 0, 0, 1, 1, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL bne: got %h want %h", act, want); end
  endtask

  task automatic test_stall_flush();
    step(1'b1, 32'h01095020, 32'h5, 32'h7, 1'b0, 1'b0);
    want = mk(1, 3, 32'h5, 32'h7, 32'h7, 10, 1, 0, 0, 0, 0, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL add: got %h want %h", act, want); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h3C080000 + k, 32'h99 + k, 32'h42, 1'b1, 1'b0);
      tests++;
      if (act !== want) begin failed++; $display("FAIL stall_hold[%0d]: got %h want %h", k, act, want); end
    end
    step(1'b1, 32'h01095020, 32'h5, 32'h7, 1'b1, 1'b1);
    tests++;
    if (act !== '0) begin failed++; $display("FAIL stall_flush: got %h want 0", act); end
    step(1'b0, 32'h01095020, 32'h5, 32'h7, 1'b0, 1'b0);
    tests++;
    if (act !== '0) begin failed++; $display("FAIL invalid_bubble: got %h want 0", act); end
  endtask

  task automatic test_illegal_nop();
    step(1'b1, 32'hFC000000, 32'h1, 32'h2, 1'b0, 1'b0);
    want = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tests++;
    if (act !== want) begin failed++; $display("FAIL illegal: got %h want %h", act, want); end
    step(1'b1, 32'h00000000, 32'h0, 32'h0, 1'b0, 1'b0);
    want = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL nop: got %h want %h", act, want); end
    step(1'b1, 32'h0000003F, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0000003F, 32'h0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (act !== '0) begin failed++; $display("FAIL illegal_stall_drop: got %h want 0", act); end
  endtask

  task automatic test_async_reset_mid();
    step(1'b1, 32'h8D090004, 32'h200, 32'h9, 1'b0, 1'b0);
    want = mk(1, 3, 32'h200, 32'h4, 32'h9, 9, 1, 1, 0, 0, 0, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL lw: got %h want %h", act, want); end
    #2 rst_n = 1'b0;
    #1;
    exp_q = '0;
    tests++;
    if (act !== '0) begin failed++; $display("FAIL reset_mid: got %h want 0", act); end
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 32'h01095020, 32'h5, 32'h7, 1'b0, 1'b0);
    want = mk(1, 3, 32'h5, 32'h7, 32'h7, 10, 1, 0, 0, 0, 0, 0);
    tests++;
    if (act !== want) begin failed++; $display("FAIL post_reset: got %h want %h", act, want); end
  endtask

  task automatic test_random();
    logic [5:0] ops [13] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                            6'h23, 6'h2B, 6'h04, 6'h05, 6'h00};
    logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h01};
    logic [31:0] i;
    for (int k = 0; k < 400; k++) begin
      i = $urandom;
      if ($urandom_range(7) != 0) begin
        i[31:26] = ops[$urandom_range(12)];
        if (i[31:26] == 6'h00) i[5:0] = fns[$urandom_range(15)];
      end
      step($urandom_range(5) != 0, i, $urandom, $urandom,
           $urandom_range(4) == 0, $urandom_range(9) == 0);
      tests++;
      if (act !== exp_q) begin failed++; $display("FAIL rand[%0d] instr %h: got %h want %h", k, i, act, exp_q); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_shift_lui();
    test_store_branch();
    test_stall_flush();
    test_illegal_nop();
    test_async_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
Decode-and-issue stage that drives the datapath ALU's op_code/operand1/operand2 interface. It takes a fetched MIPS-I instruction and its register-file read data, decodes it into the ALU's 4-bit operation code and operands, and produces memory, writeback and branch control. All outputs are registered in the ID/EX pipeline register, which supports stall and flush. It sits between the register file and the ALU.

Parameters:
N, 32, datapath width. Matches the ALU operand and result width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  instr and the register data are valid this cycle
instr  in  32  MIPS instruction word
rs_data  in  N  register-file value of instr[25:21]
rt_data  in  N  register-file value of instr[20:16]
stall  in  1  hold the ID/EX register
flush  in  1  replace the ID/EX contents with a bubble
ex_valid  out  1  ID/EX holds a real instruction
ex_op_code  out  4  ALU op: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT
ex_operand1  out  N  ALU operand1; for shifts, the shift amount in bits [4:0]
ex_operand2  out  N  ALU operand2; for shifts, the value being shifted
ex_store_data  out  N  rt_data, for SW
ex_dest_reg  out  5  writeback register index
ex_reg_write  out  1  write the result back
ex_mem_read  out  1  LW
ex_mem_write  out  1  SW
ex_branch  out  1  BEQ or BNE
ex_branch_ne  out  1  1 = BNE, 0 = BEQ
ex_illegal  out  1  one-cycle pulse: an unsupported instruction was captured

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0, including ex_op_code = 0. Reset may be asserted at any time, including mid-stall.
- Register update on each rising clk edge, priority order:
  1. flush = 1: load a bubble. Takes priority over stall.
  2. stall = 1: hold all outputs, except ex_illegal, which drops to 0.
  3. instr_valid = 0: load a bubble.
  4. Otherwise: load the decoded instruction.
- Bubble: ex_valid and all control bits = 0; data fields = 0; ex_illegal = 0.
- Latency: 1 cycle from input to registered output. Decode is purely combinational ahead of the register.
- Field names: op = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], funct = [5:0], imm = [15:0].
- Immediates: SE = imm sign-extended to N; ZE = imm zero-extended to N.
- R-type (op 0x00), dest = rd, reg_write = 1:
  - funct 0x00 SLL: op 0, operand1 = ZE(shamt), operand2 = rt_data.
  - funct 0x02 SRL: op 1, operands as SLL.
  - funct 0x03 SRA: op 2, operands as SLL.
  - funct 0x04 SLLV / 0x06 SRLV / 0x07 SRAV: op 0 / 1 / 2, operand1 = rs_data, operand2 = rt_data.
  - funct 0x20 ADD / 0x21 ADDU: op 3.
  - funct 0x22 SUB / 0x23 SUBU: op 4.
  - funct 0x24 AND: op 5. 0x25 OR: op 6. 0x26 XOR: op 7. 0x27 NOR: op 8. 0x2A SLT: op 9.
  - For these non-shift functs: operand1 = rs_data, operand2 = rt_data.
- I-type, dest = rt, operand1 = rs_data unless stated:
  - 0x08 ADDI / 0x09 ADDIU: op 3, operand2 = SE.
  - 0x0A SLTI: op 9, operand2 = SE.
  - 0x0C ANDI / 0x0D ORI / 0x0E XORI: op 5 / 6 / 7, operand2 = ZE.
  - 0x0F LUI: op 0, operand1 = 16, operand2 = ZE.
  - 0x23 LW: op 3, operand2 = SE, mem_read = 1, reg_write = 1.
  - 0x2B SW: op 3, operand2 = SE, mem_write = 1, reg_write = 0, store_data = rt_data.
  - 0x04 BEQ / 0x05 BNE: op 4, operand2 = rt_data, branch = 1, branch_ne = (op == 0x05), reg_write = 0.
- ex_reg_write is forced to 0 whenever dest = 0. Consequence: 0x00000000 (NOP) issues with ex_valid = 1 and no writeback.
- Any other op/funct is illegal: it loads a bubble and sets ex_illegal = 1 for exactly one cycle.
- ex_store_data = rt_data for every valid instruction; 0 in a bubble.

Test Plan:
- ADDI 0x2109FFFB, rs_data = 0x10 -> next cycle: ex_op_code = 3, operand1 = 0x10, operand2 = 0xFFFFFFFB, dest = 9, reg_write = 1, ex_valid = 1.
- SLL 0x00095100, rt_data = 0x3 -> op 0, operand1 = 4, operand2 = 3, dest = 10. Then LUI 0x3C081234 -> op 0, operand1 = 16, operand2 = 0x00001234, dest = 8.
- SW 0xAD090008, rs_data = 0x100, rt_data = 0xCAFE -> op 3, operand2 = 8, mem_write = 1, reg_write = 0, store_data = 0xCAFE.
- Issue ADD, then stall for 3 cycles while changing instr -> outputs frozen on ADD. Then stall = 1 and flush = 1 together -> bubble (ex_valid = 0).
- instr = 0xFC000000 -> ex_illegal = 1 for one cycle, ex_valid = 0. NOP 0x00000000 -> ex_valid = 1, reg_write = 0.
- Assert rst_n low mid-cycle during a valid LW -> all outputs 0 immediately, without waiting for clk; normal capture resumes on the first edge after release.
